// File: rtl/mochila_ext_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mochila_ext_slave_bridge
// Description : Buffered OBI bridge from the mochila external-slave port to the
//               SoC slave, with outstanding limit and response timeout.
//               Optional macro MOCHILA_BRIDGE_STATS_EN adds transaction stats.
// Bus packing : obi req  = {req, we, be[3:0], addr[31:0], wdata[31:0]} (70 b)
//               obi resp = {gnt, rvalid, rdata[31:0]}                  (34 b)
// Revision    : 1.0 - initial release
// ============================================================================
module mochila_ext_slave_bridge #(
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          TIMEOUT_CYCLES  = 256,
   parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [69:0] up_req_i,
   output logic [33:0] up_resp_o,
   output logic [69:0] dn_req_o,
   input  logic [33:0] dn_resp_i,
   output logic        timeout_o,
   output logic        busy_o
`ifdef MOCHILA_BRIDGE_STATS_EN
   ,
   output logic [31:0] stat_txn_o,
   output logic [15:0] stat_timeout_o
`endif
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
   localparam int DROP_W = 8;

   localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);
   localparam logic [OUT_W-1:0]  MAX_OUT       = OUT_W'(MAX_OUTSTANDING);
   localparam logic [TMR_W-1:0]  TMR_MAX       = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [TMR_W-1:0]    timer;
   logic [TMR_W-1:0]    timer_nx;
   logic [OUT_W-1:0]    up_cnt;
   logic [OUT_W-1:0]    up_cnt_nx;
   logic [OUT_W-1:0]    dn_cnt;
   logic [OUT_W-1:0]    dn_cnt_nx;
   logic [DROP_W-1:0]   drop_cnt;
   logic [DROP_W-1:0]   drop_cnt_nx;

   logic [68:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [FCNT_W-1:0]   fifo_cnt;
   logic [FCNT_W-1:0]   fifo_cnt_nx;
   logic                fifo_empty;
   logic                fifo_full;

   logic                rvalid_q;
   logic [31:0]         rdata_q;
   logic                timeout_q;
   logic                busy_q;

   logic                up_req;
   logic                gnt;
   logic                push;
   logic                pop;
   logic                dn_gnt;
   logic                dn_rv;
   logic                drop_rv;
   logic                fwd_rv;
   logic                fire_to;
   logic                drop_inc;

   assign up_req     = up_req_i[69];
   assign dn_gnt     = dn_resp_i[33];
   assign dn_rv      = dn_resp_i[32];
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);

   // Full flag is taken before any same-cycle pop, so a full FIFO never pushes.
   assign gnt  = up_req & ~fifo_full & (up_cnt < MAX_OUT) & ~rst_i;
   assign push = gnt;
   assign pop  = ~fifo_empty & dn_gnt;

   // A pending drop absorbs the rvalid first, including one landing in ERR.
   assign drop_rv  = dn_rv & (drop_cnt != '0);
   assign fwd_rv   = dn_rv & (drop_cnt == '0) & (dn_cnt != '0);
   assign fire_to  = (state == WAIT) & (timer == TMR_MAX) & ~dn_rv;
   assign drop_inc = fire_to & (drop_cnt != '1);

   assign up_cnt_nx   = up_cnt + OUT_W'(gnt) - OUT_W'(rvalid_q);
   assign dn_cnt_nx   = dn_cnt + OUT_W'(pop) - OUT_W'(fwd_rv | fire_to);
   assign drop_cnt_nx = drop_cnt + DROP_W'(drop_inc) - DROP_W'(drop_rv);
   assign fifo_cnt_nx = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);

   always_comb begin
      state_nx = IDLE;
      timer_nx = '0;
      if (fire_to) begin
         state_nx = ERR;
      end else if (dn_cnt_nx != '0) begin
         state_nx = WAIT;
      end
      if ((state == WAIT) && (state_nx == WAIT) && !dn_rv) begin
         timer_nx = timer + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= up_req_i[68:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         timer     <= '0;
         up_cnt    <= '0;
         dn_cnt    <= '0;
         drop_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         timer    <= timer_nx;
         up_cnt   <= up_cnt_nx;
         dn_cnt   <= dn_cnt_nx;
         drop_cnt <= drop_cnt_nx;
         fifo_cnt <= fifo_cnt_nx;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         rvalid_q  <= fwd_rv | fire_to;
         timeout_q <= fire_to;
         if (fire_to) begin
            rdata_q <= ERR_RDATA;
         end else if (fwd_rv) begin
            rdata_q <= dn_resp_i[31:0];
         end else begin
            rdata_q <= '0;
         end
         busy_q <= (fifo_cnt_nx != '0) | (up_cnt_nx != '0);
      end
   end

   assign up_resp_o = {gnt, rvalid_q, rdata_q};
   assign dn_req_o  = fifo_empty ? 70'd0 : {1'b1, mem[rd_ptr]};
   assign timeout_o = timeout_q;
   assign busy_o    = busy_q;

`ifdef MOCHILA_BRIDGE_STATS_EN
   logic [31:0] stat_txn_q;
   logic [15:0] stat_timeout_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_txn_q     <= '0;
         stat_timeout_q <= '0;
      end else begin
         if ((fwd_rv | fire_to) && (stat_txn_q != '1)) begin
            stat_txn_q <= stat_txn_q + 1'b1;
         end
         if (fire_to && (stat_timeout_q != '1)) begin
            stat_timeout_q <= stat_timeout_q + 1'b1;
         end
      end
   end

   assign stat_txn_o     = stat_txn_q;
   assign stat_timeout_o = stat_timeout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mochila_ext_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mochila_ext_slave_bridge
// Description : Directed self-checking bench with a small downstream slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mochila_ext_slave_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [69:0] up_req;
   logic [33:0] up_resp;
   logic [69:0] dn_req;
   logic [33:0] dn_resp;
   logic        timeout;
   logic        busy;
`ifdef MOCHILA_BRIDGE_STATS_EN
   logic [31:0] stat_txn;
   logic [15:0] stat_timeout;
`endif

   mochila_ext_slave_bridge dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .up_req_i  (up_req),
      .up_resp_o (up_resp),
      .dn_req_o  (dn_req),
      .dn_resp_i (dn_resp),
      .timeout_o (timeout),
      .busy_o    (busy)
`ifdef MOCHILA_BRIDGE_STATS_EN
      ,
      .stat_txn_o     (stat_txn),
      .stat_timeout_o (stat_timeout)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Downstream slave model: grants when m_gnt, answers after m_lat cycles when m_auto.
   bit          m_gnt  = 1'b0;
   bit          m_auto = 1'b0;
   int          m_lat  = 2;
   logic [31:0] m_rd_val = 32'h0;
   int          inject_cycle = -1;
   logic [31:0] inject_data  = 32'h0;
   int          due_q[$];
   logic [31:0] dat_q[$];
   logic [31:0] pop_addr_q[$];

   initial begin
      dn_resp = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            due_q.delete();
            dat_q.delete();
         end
         dn_resp[33] = m_gnt;
         if (!rst && m_gnt && dn_req[69]) begin
            pop_addr_q.push_back(dn_req[63:32]);
            if (m_auto) begin
               due_q.push_back(cyc + m_lat);
               dat_q.push_back(dn_req[68] ? 32'h0 : m_rd_val);
            end
         end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            dn_resp[32]   = 1'b1;
            dn_resp[31:0] = dat_q.pop_front();
            void'(due_q.pop_front());
         end else if (cyc == inject_cycle) begin
            dn_resp[32]   = 1'b1;
            dn_resp[31:0] = inject_data;
         end else begin
            dn_resp[32]   = 1'b0;
            dn_resp[31:0] = 32'h0;
         end
      end
   end

   // Upstream response monitor
   logic [31:0] rsp_data[$];
   int          to_cnt = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (up_resp[32]) rsp_data.push_back(up_resp[31:0]);
         if (timeout) to_cnt++;
      end
   end

   function automatic logic [69:0] mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      return {1'b1, we, 4'hF, addr, wdata};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request at the current cycle and wait (bounded) for its response.
   task automatic single_req(input string tag, input logic we, input logic [31:0] addr,
                             output int lat, output logic [31:0] data);
      int start;
      int n;
      up_req = mk(we, addr, 32'h0);
      #1;
      check({tag, "_gnt"}, up_resp[33], 1'b1);
      start = cyc;
      tick();
      up_req = '0;
      n = 0;
      while (!up_resp[32] && n < 600) begin
         tick();
         n++;
      end
      lat  = cyc - start;
      data = up_resp[31:0];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] data;
      int          n;
      int          base_rsp;
      int          base_pop;
      int          base_to;

      up_req = mk(1'b0, 32'h0000_0040, 32'h0);
      rst    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",    up_resp[33], 1'b0);
      check("rst_rvalid", up_resp[32], 1'b0);
      check("rst_rdata",  up_resp[31:0], 32'h0);
      check("rst_dn_req", {31'h0, |dn_req}, 32'h0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_busy",   busy, 1'b0);
      up_req = '0;
      rst    = 1'b0;
      tick();
      tick();

      // Single read, cycle accurate
      m_gnt = 1'b1; m_auto = 1'b1; m_lat = 2; m_rd_val = 32'h1234_5678;
      up_req = mk(1'b0, 32'h0000_1000, 32'h0);
      #1;
      check("t1_c0_gnt",    up_resp[33], 1'b1);
      check("t1_c0_dn_req", dn_req[69], 1'b0);
      tick();
      up_req = '0;
      check("t1_c1_dn_req",  dn_req[69], 1'b1);
      check("t1_c1_dn_addr", dn_req[63:32], 32'h0000_1000);
      check("t1_c1_dn_we",   dn_req[68], 1'b0);
      check("t1_c1_busy",    busy, 1'b1);
      tick();
      check("t1_c2_rvalid", up_resp[32], 1'b0);
      tick();
      check("t1_c3_rvalid", up_resp[32], 1'b0);
      tick();
      check("t1_c4_rvalid", up_resp[32], 1'b1);
      check("t1_c4_rdata",  up_resp[31:0], 32'h1234_5678);
      check("t1_c4_busy",   busy, 1'b1);
      tick();
      check("t1_c5_rvalid", up_resp[32], 1'b0);
      check("t1_c5_busy",   busy, 1'b0);
      tick();

      // Six back-to-back writes with downstream grant held low
      m_gnt = 1'b0; m_auto = 1'b1; m_lat = 1;
      base_rsp = rsp_data.size();
      base_pop = pop_addr_q.size();
      for (int i = 0; i < 4; i++) begin
         up_req = mk(1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
         #1;
         check("t2_wr_gnt", up_resp[33], 1'b1);
         tick();
      end
      up_req = mk(1'b1, 32'h110, 32'hC0DE_0004);
      tick();
      tick();
      check("t2_stall_gnt", up_resp[33], 1'b0);
      check("t2_stall_busy", busy, 1'b1);
      m_gnt = 1'b1;
      for (int i = 4; i < 6; i++) begin
         up_req = mk(1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
         #1;
         n = 0;
         while (!up_resp[33] && n < 50) begin
            tick();
            n++;
         end
         check("t2_late_gnt", up_resp[33], 1'b1);
         tick();
      end
      up_req = '0;
      n = 0;
      while (rsp_data.size() < base_rsp + 6 && n < 100) begin
         tick();
         n++;
      end
      check("t2_rsp_count", rsp_data.size() - base_rsp, 6);
      check("t2_busy_after", busy, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (base_pop + i < pop_addr_q.size())
            check("t2_order", pop_addr_q[base_pop + i], 32'h100 + 32'(4 * i));
         else
            check("t2_order_missing", 32'h0, 32'h100 + 32'(4 * i));
         if (base_rsp + i < rsp_data.size())
            check("t2_wr_rdata", rsp_data[base_rsp + i], 32'h0);
      end
      tick();

      // Downstream never answers -> synthetic response, late rvalid dropped
      m_gnt = 1'b1; m_auto = 1'b0;
      base_to = to_cnt;
      single_req("t3", 1'b0, 32'h0000_2000, lat, data);
      check("t3_latency", lat, 258);
      check("t3_rdata",   data, 32'hDEAD_BEEF);
      check("t3_timeout", timeout, 1'b1);
      tick();
      check("t3_timeout_pulse", timeout, 1'b0);
      check("t3_rvalid_pulse",  up_resp[32], 1'b0);
      check("t3_busy",          busy, 1'b0);
      base_rsp     = rsp_data.size();
      inject_data  = 32'h5555_0000;
      inject_cycle = cyc + 10;
      repeat (14) tick();
      check("t3_late_dropped", rsp_data.size() - base_rsp, 0);
      check("t3_to_count",     to_cnt - base_to, 1);

      // Threshold coincides with downstream rvalid: forwarded, no timeout
      m_auto = 1'b1; m_lat = 256; m_rd_val = 32'hA5A5_A5A5;
      base_to = to_cnt;
      single_req("t4", 1'b0, 32'h0000_2004, lat, data);
      check("t4_latency", lat, 258);
      check("t4_rdata",   data, 32'hA5A5_A5A5);
      check("t4_timeout", timeout, 1'b0);
      tick();
      check("t4_no_timeout", to_cnt - base_to, 0);
      check("t4_busy",       busy, 1'b0);

      // Reset with three outstanding reads, then a normal read
      m_auto = 1'b0; m_gnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         up_req = mk(1'b0, 32'h3000 + 32'(4 * i), 32'h0);
         #1;
         check("t5_gnt", up_resp[33], 1'b1);
         tick();
      end
      up_req = '0;
      tick();
      check("t5_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick();
      check("t5_rst_resp",    {31'h0, |up_resp}, 32'h0);
      check("t5_rst_dn_req",  {31'h0, |dn_req}, 32'h0);
      check("t5_rst_timeout", timeout, 1'b0);
      check("t5_rst_busy",    busy, 1'b0);
      rst = 1'b0;
      tick();
      m_auto = 1'b1; m_lat = 2; m_rd_val = 32'h0BAD_CAFE;
      single_req("t5", 1'b0, 32'h0000_4000, lat, data);
      check("t5_latency", lat, 4);
      check("t5_rdata",   data, 32'h0BAD_CAFE);
      tick();

`ifdef MOCHILA_BRIDGE_STATS_EN
      rst = 1'b1;
      tick();
      check("st_rst_txn", stat_txn, 32'h0);
      rst = 1'b0;
      tick();
      m_auto = 1'b1; m_lat = 2; m_rd_val = 32'h7777_0000;
      for (int i = 0; i < 5; i++) begin
         single_req("st", 1'b0, 32'h5000 + 32'(4 * i), lat, data);
         check("st_rdata", data, 32'h7777_0000);
         tick();
      end
      m_auto = 1'b0;
      single_req("st_to", 1'b0, 32'h0000_6000, lat, data);
      check("st_to_rdata", data, 32'hDEAD_BEEF);
      tick();
      check("st_txn",     stat_txn, 32'd6);
      check("st_timeout", {16'h0, stat_timeout}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
